// File: rtl/alu_check_pkg.sv
// Shared types and helpers for the ALU result checker.
package alu_check_pkg;

    // ALU function codes as applied to the device under check.
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_RSVD = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_func_t;

    // Checker run states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: expected result and flags for one vector.
module alu_ref_model
    import alu_check_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       f_i,
    output logic [WIDTH-1:0] exp_y_o,
    output logic             exp_overflow_o,
    output logic             exp_zero_o,
    output logic             reserved_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic           add_ovf_w;
    logic           sub_ovf_w;
    logic           slt_w;
    alu_func_t      func_w;

    // Sum and difference carried one bit wider; signed overflow is the
    // carry into the MSB XOR the carry out of it.
    always_comb begin
        func_w    = alu_func_t'(f_i);
        sum_w     = {1'b0, a_i} + {1'b0, b_i};
        diff_w    = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf_w = sum_w[WIDTH] ^ (a_i[MSB] ^ b_i[MSB] ^ sum_w[MSB]);
        sub_ovf_w = diff_w[WIDTH] ^ (a_i[MSB] ^ ~b_i[MSB] ^ diff_w[MSB]);
        slt_w     = diff_w[MSB] ^ sub_ovf_w;
    end

    // Result and flag selection by function code.
    always_comb begin
        exp_y_o        = '0;
        exp_overflow_o = 1'b0;
        reserved_o     = 1'b0;
        case (func_w)
            ALU_AND:  exp_y_o = a_i & b_i;
            ALU_OR:   exp_y_o = a_i | b_i;
            ALU_ADD: begin
                exp_y_o        = sum_w[WIDTH-1:0];
                exp_overflow_o = add_ovf_w;
            end
            ALU_RSVD: reserved_o = 1'b1;
            ALU_ANDN: exp_y_o = a_i & ~b_i;
            ALU_ORN:  exp_y_o = a_i | ~b_i;
            ALU_SUB: begin
                exp_y_o        = diff_w[WIDTH-1:0];
                exp_overflow_o = sub_ovf_w;
            end
            ALU_SLT:  exp_y_o = {{(WIDTH-1){1'b0}}, slt_w};
        endcase
        exp_zero_o = (exp_y_o == '0);
    end

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking sink for the 32-bit ALU with flags. Vectors are registered
// in S1, checked against the golden model in S2, and tallied.
//
// Handshake: a vector is taken when IN_VALID is high on a clock edge while
// the checker is in RUN and START is low; there is no back-pressure, so any
// vector presented outside those conditions is silently dropped.
module alu_result_checker #(
    parameter int WIDTH       = 32,
    parameter int MAX_VECTORS = 1024
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       F,
    input  logic [WIDTH-1:0] Y,
    input  logic             OVERFLOW,
    input  logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [31:0]      vectorsNum,
    output logic [31:0]      errorsNum,
    output logic [31:0]      skippedNum,
    output logic             FIRST_ERR_VALID,
    output logic [31:0]      FIRST_ERR_INDEX,
    output logic [2:0]       FIRST_ERR_F,
    output logic [WIDTH-1:0] FIRST_ERR_Y,
    output logic [WIDTH-1:0] FIRST_ERR_EXPECTED
);

    import alu_check_pkg::*;

    localparam logic [31:0] LIMIT_M1 = 32'(MAX_VECTORS - 1);

    // FSM and acceptance bookkeeping
    chk_state_t state_q;
    logic       drain_q;
    logic [31:0] acc_q;
    logic       accept_w;
    logic       limit_hit_w;

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_f_q;
    logic [WIDTH-1:0] s1_y_q;
    logic             s1_ovf_q;
    logic             s1_zero_q;

    // Stage 2 compare results
    logic [WIDTH-1:0] exp_y_w;
    logic             exp_ovf_w;
    logic             exp_zero_w;
    logic             reserved_w;
    logic             mismatch_w;
    logic             cmp_w;
    logic             skip_w;
    logic             err_w;

    // Counters and first-error capture
    logic [31:0]      vec_q;
    logic [31:0]      err_q;
    logic [31:0]      skip_q;
    logic             fe_valid_q;
    logic [31:0]      fe_index_q;
    logic [2:0]       fe_f_q;
    logic [WIDTH-1:0] fe_y_q;
    logic [WIDTH-1:0] fe_exp_q;

    // A vector is taken only in RUN; START drops the vector of its own cycle.
    // The limit trips on the vector that brings the accepted count to MAX.
    always_comb begin
        accept_w    = (state_q == RUN) && IN_VALID && !START;
        limit_hit_w = (MAX_VECTORS != 0) && accept_w && (acc_q == LIMIT_M1);
    end

    // Run-control FSM; START overrides STOP and the limit in every state.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            acc_q   <= '0;
        end else if (START) begin
            state_q <= RUN;
            drain_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            if (accept_w) begin
                acc_q <= sat_inc(acc_q);
            end
            case (state_q)
                IDLE: begin
                end
                RUN: begin
                    if (STOP || limit_hit_w) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // One cycle for S1 to empty, one for S2 to retire.
                    if (drain_q) begin
                        state_q <= alu_check_pkg::DONE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                alu_check_pkg::DONE: begin
                end
            endcase
        end
    end

    // S1: register the vector and DUT response when accepted.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_f_q     <= '0;
            s1_y_q     <= '0;
            s1_ovf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept_w;
            if (accept_w) begin
                s1_a_q    <= A;
                s1_b_q    <= B;
                s1_f_q    <= F;
                s1_y_q    <= Y;
                s1_ovf_q  <= OVERFLOW;
                s1_zero_q <= ZERO;
            end
        end
    end

    alu_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .a_i           (s1_a_q),
        .b_i           (s1_b_q),
        .f_i           (s1_f_q),
        .exp_y_o       (exp_y_w),
        .exp_overflow_o(exp_ovf_w),
        .exp_zero_o    (exp_zero_w),
        .reserved_o    (reserved_w)
    );

    // S2: compare DUT response with expected; X/Z on the response in
    // simulation counts as a mismatch.
    always_comb begin
`ifdef SYNTHESIS
        mismatch_w = (s1_y_q != exp_y_w) || (s1_ovf_q != exp_ovf_w) ||
                     (s1_zero_q != exp_zero_w);
`else
        mismatch_w = (s1_y_q !== exp_y_w) || (s1_ovf_q !== exp_ovf_w) ||
                     (s1_zero_q !== exp_zero_w);
`endif
        cmp_w  = s1_valid_q && !reserved_w;
        skip_w = s1_valid_q && reserved_w;
        err_w  = cmp_w && mismatch_w;
    end

    // S2: counters and first-error capture; START clears, capture is sticky.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            vec_q      <= '0;
            err_q      <= '0;
            skip_q     <= '0;
            fe_valid_q <= 1'b0;
            fe_index_q <= '0;
            fe_f_q     <= '0;
            fe_y_q     <= '0;
            fe_exp_q   <= '0;
        end else if (START) begin
            vec_q      <= '0;
            err_q      <= '0;
            skip_q     <= '0;
            fe_valid_q <= 1'b0;
            fe_index_q <= '0;
            fe_f_q     <= '0;
            fe_y_q     <= '0;
            fe_exp_q   <= '0;
        end else begin
            if (cmp_w) begin
                vec_q <= sat_inc(vec_q);
            end
            if (err_w) begin
                err_q <= sat_inc(err_q);
            end
            if (skip_w) begin
                skip_q <= sat_inc(skip_q);
            end
            if (err_w && !fe_valid_q) begin
                fe_valid_q <= 1'b1;
                fe_index_q <= vec_q;
                fe_f_q     <= s1_f_q;
                fe_y_q     <= s1_y_q;
                fe_exp_q   <= exp_y_w;
            end
        end
    end

    // Status decode and output mapping.
    always_comb begin
        BUSY               = (state_q == RUN) || (state_q == DRAIN);
        DONE               = (state_q == alu_check_pkg::DONE);
        PASS               = DONE && (err_q == '0) && (vec_q != '0);
        vectorsNum         = vec_q;
        errorsNum          = err_q;
        skippedNum         = skip_q;
        FIRST_ERR_VALID    = fe_valid_q;
        FIRST_ERR_INDEX    = fe_index_q;
        FIRST_ERR_F        = fe_f_q;
        FIRST_ERR_Y        = fe_y_q;
        FIRST_ERR_EXPECTED = fe_exp_q;
    end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Synthesizable self-checking sink for the 32-bit ALU with flags. It receives each applied vector (A, B, F) together with the DUT response (Y, OVERFLOW, ZERO) and recomputes the expected result internally. It counts vectors and mismatches, captures the first failing vector, and reports pass/fail. It lets the same ALU be exercised on-chip or in a bench without vector files.

Parameters:
WIDTH, 32, operand/result width
MAX_VECTORS, 1024, run ends automatically after this many accepted vectors; 0 = unlimited

Ports:
clk  in  1  clock, all logic on posedge
RESET  in  1  asynchronous, active-high reset
START  in  1  one-cycle pulse: clear counters/capture, enter RUN
STOP  in  1  one-cycle pulse: end run (RUN -> DRAIN)
IN_VALID  in  1  vector + response valid this cycle
A  in  WIDTH  operand A applied to the ALU
B  in  WIDTH  operand B applied to the ALU
F  in  3  ALU function code
Y  in  WIDTH  ALU result
OVERFLOW  in  1  ALU overflow flag
ZERO  in  1  ALU zero flag
BUSY  out  1  state is RUN or DRAIN
DONE  out  1  state is DONE
PASS  out  1  valid only when DONE=1; errorsNum==0 and vectorsNum!=0
vectorsNum  out  32  compared vectors (excludes skipped)
errorsNum  out  32  mismatching vectors
skippedNum  out  32  vectors with reserved F=3'b011
FIRST_ERR_VALID  out  1  first-error capture holds data
FIRST_ERR_INDEX  out  32  vectorsNum value of the first failing vector (0-based)
FIRST_ERR_F  out  3  F of the first failing vector
FIRST_ERR_Y  out  WIDTH  DUT Y of the first failing vector
FIRST_ERR_EXPECTED  out  WIDTH  expected Y of the first failing vector

Behaviour:
- Reset: state IDLE. All outputs 0.
- Function codes:
  - 000 A&B; 001 A|B; 010 A+B; 100 A&~B; 101 A|~B; 110 A-B.
  - 111 SLT: Y = {0..0, signed A<signed B}, computed from the sign of A-B XOR the subtraction overflow.
  - 011 is reserved: no compare, skippedNum++.
- Expected flags:
  - OVERFLOW is the signed two's-complement overflow for 010 and 110; 0 for all other codes.
  - ZERO = (expected Y == 0).
- A mismatch on any of Y, OVERFLOW or ZERO is an error. Comparison uses 4-state inequality in simulation and plain inequality in synthesis.
- Pipeline, 2 stages:
  - S1 registers IN_VALID/A/B/F/Y/flags when state==RUN; IN_VALID is ignored in any other state.
  - S2 computes expected, compares, and updates counters.
  - Counters and captures update 2 cycles after the accepted IN_VALID edge.
- Counters saturate at 32'hFFFF_FFFF. Sum arithmetic is WIDTH+1 bits internally; results are truncated to WIDTH.
- First-error capture loads only while FIRST_ERR_VALID=0, then holds until START.
- FSM:
  - IDLE -START-> RUN.
  - RUN -STOP, or accepted count (vectors + skipped) reaching MAX_VECTORS-> DRAIN. The vector that reaches the limit is itself accepted; IN_VALID in later cycles is dropped.
  - DRAIN waits until S1 and S2 are empty (2 cycles) -> DONE.
  - DONE -START-> RUN.
- START in any state:
  - Clears counters, captures and pipeline valids, then enters RUN next cycle.
  - START wins over a simultaneous STOP or limit.
  - IN_VALID in the START cycle is dropped.
- STOP in IDLE or DONE is ignored.
- RESET asserted mid-run: immediate return to IDLE with all outputs 0, asynchronously.

Decomposition:
- Package alu_check_pkg holds:
  - typedef enum logic[2:0] alu_func_t: ALU_AND, ALU_OR, ALU_ADD, ALU_RSVD, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT.
  - typedef enum logic[1:0] chk_state_t: IDLE, RUN, DRAIN, DONE.
- One sub-module, alu_ref_model: purely combinational golden ALU (A, B, F -> expY, expOVERFLOW, expZERO, reserved), instantiated in S2.

Test Plan:
- Reset mid-run: RESET high 1 cycle during RUN after 5 vectors -> BUSY=0, DONE=0, vectorsNum=0 immediately, FIRST_ERR_VALID=0.
- Correct ADD overflow: START; one vector A=7FFF_FFFF, B=1, F=010, Y=8000_0000, OVERFLOW=1, ZERO=0; then STOP -> DONE after drain, PASS=1, vectorsNum=1, errorsNum=0.
- SUB producing zero: A=5, B=5, F=110, Y=0, ZERO=0 (wrong flag) -> errorsNum=1, FIRST_ERR_INDEX=0, FIRST_ERR_EXPECTED=0, FIRST_ERR_Y=0.
- SLT signed: A=FFFF_FFFF, B=1, F=111, Y=1 -> pass. Then the same with Y=0 as vector 1 -> errorsNum=1, FIRST_ERR_INDEX=1.
- Reserved code and limit: MAX_VECTORS=4; send 2 vectors with F=011 and 3 with F=000, all correct -> skippedNum=2, vectorsNum=2 (5th dropped), DONE without STOP, PASS=1.
- Restart and priority: while DONE with errorsNum=3, assert START and STOP together -> state RUN, all counters 0, FIRST_ERR_VALID=0.
